pipelined_priority_arbiter: RTL and testbench
=============================================

# pipelined_priority_arbiter

Registered, handshaked successor to the combinational priority encoder. It arbitrates an INPUT_WIDTH-bit request vector in one of two runtime-selectable modes, fixed MSB-first or round-robin. The winner is registered and held stable until the consumer accepts it. It sits between request sources (DMA channels, FIFO-not-empty flags) and a single shared downstream resource.

## Interface
- INPUT_WIDTH, 8: number of requesters; must be ≥ 2.
- OUTPUT_WIDTH, $clog2(INPUT_WIDTH): width of the grant index.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  INPUT_WIDTH  per-requester request level.
- mode  input  1  0 = fixed priority (MSB highest); 1 = round-robin.
- grant_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  a grant is presented.
- grant_index  output  OUTPUT_WIDTH  binary index of the granted requester.
- grant_onehot  output  INPUT_WIDTH  one-hot form of grant_index; all zeros when grant_valid=0.
- last_index  output  OUTPUT_WIDTH  index of the most recently accepted grant (round-robin pointer).

## Operation
- States:
  - IDLE: grant_valid=0.
  - HOLD: grant_valid=1, grant outputs frozen.
- Arbitration is combinational from request, mode and last_index. Its result is registered only when the arbiter is "open". Open means state IDLE, or state HOLD with grant_ready=1 (accept).
- Fixed mode: the winner is the highest set bit of request.
- Round-robin mode: the search starts at (last_index − 1) mod INPUT_WIDTH and walks downward with wrap-around. The first set bit wins. last_index itself has the lowest priority.
- Transitions:
  - IDLE, request≠0: load winner, go to HOLD.
  - IDLE, request=0: stay in IDLE.
  - HOLD, grant_ready=0: stay in HOLD. grant_index and grant_onehot do not change, even if request changes or the granted bit drops. Grants are sticky.
  - HOLD, grant_ready=1 (accept): last_index ← grant_index. If the arbitration of the same cycle finds request≠0, load the new winner and stay in HOLD (back-to-back). Otherwise go to IDLE.
- Back-to-back arbitration in round-robin mode uses the updated pointer. The pointer used equals the index being accepted this cycle, not the stale last_index.
- mode is sampled only when the arbiter is open. Changing mode while in HOLD has no effect on the held grant.
- last_index updates on every accept in both modes. Fixed mode ignores it.
- Width rule: all index arithmetic is modulo INPUT_WIDTH. When INPUT_WIDTH is not a power of two, (0 − 1) wraps to INPUT_WIDTH−1, not to 2^OUTPUT_WIDTH−1.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE.
  - grant_valid=0, grant_index=0, grant_onehot=0.
  - last_index=0. In round-robin mode the first search therefore starts at INPUT_WIDTH−1, identical to fixed mode.
- Latency: a request visible at edge N produces grant_valid=1 after edge N (valid in cycle N+1). Minimum request-to-grant latency is 1 cycle.
- Throughput: one grant per cycle while grant_ready=1 and request≠0.
- Accept completes on an edge where grant_valid=1 and grant_ready=1.
- grant_ready while grant_valid=0 is ignored and does not move last_index.
- A reset asserted mid-HOLD drops grant_valid immediately and loses the pending grant. The first grant after reset release follows the reset-state rules.
- No combinational path from request, mode or grant_ready to any output. All outputs are direct register outputs.

## Test plan
- Reset, then request=8'b0000_0000 for 3 cycles -> grant_valid=0 and grant_onehot=0 throughout. Assert rst mid-HOLD -> grant_valid=0 in the same cycle without waiting for a clock edge.
- Fixed mode, request=8'b0010_0110, grant_ready=1 -> grant_index=5 every cycle. Drop bit 5 -> grant_index=2 on the next cycle.
- Fixed mode, request=8'b1000_0001, grant_ready=0 for 4 cycles, with request changed to 8'b0000_0001 in cycle 2 -> grant_index stays 7 with grant_valid=1 for all 4 cycles. Raise grant_ready -> accepted, then grant_index=0.
- Round-robin, request=8'hFF held, grant_ready=1 -> grant_index sequence 7,6,5,4,3,2,1,0,7. last_index trails the grant by one accept.
- Round-robin, request=8'b1000_1000, grant_ready=1 -> grant_index alternates 7,3,7,3. Switch mode to 0 while HOLD with grant_ready=0 -> the held grant is unchanged. The next open cycle grants 7.
- INPUT_WIDTH=5, round-robin, request=5'b10001, grant_ready=1 -> sequence 4,0,4,0. Pointer wrap from 0 goes to 4; index 7 is never produced.

Source files
------------

// File: rtl/pipelined_priority_arbiter.sv
// pipelined_priority_arbiter: registered fixed/round-robin arbiter with a sticky grant
// and a valid/ready handshake toward a single downstream consumer.
module pipelined_priority_arbiter #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  request,
    input  logic                    mode,
    input  logic                    grant_ready,
    output logic                    grant_valid,
    output logic [OUTPUT_WIDTH-1:0] grant_index,
    output logic [INPUT_WIDTH-1:0]  grant_onehot,
    output logic [OUTPUT_WIDTH-1:0] last_index
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] index_q, index_d, last_q, last_d;
    logic [INPUT_WIDTH-1:0]  onehot_q, onehot_d;
    logic [OUTPUT_WIDTH-1:0] ptr, win_fixed, win_rr, win;
    logic                    accept, open_w;
    int                      best_d;

    // Downward distance from the round-robin pointer; the pointer itself ranks last.
    function automatic int rr_dist(int p, int j);
        return (p + INPUT_WIDTH - 1 - j) % INPUT_WIDTH;
    endfunction

    assign accept = (state_q == HOLD) && grant_ready;
    assign open_w = (state_q == IDLE) || grant_ready;
    assign ptr    = accept ? index_q : last_q;
    assign win    = mode ? win_rr : win_fixed;

    always_comb begin
        win_fixed = '0;
        for (int j = 0; j < INPUT_WIDTH; j++)
            if (request[j]) win_fixed = OUTPUT_WIDTH'(j);
    end

    always_comb begin
        win_rr = '0;
        best_d = INPUT_WIDTH;
        for (int j = 0; j < INPUT_WIDTH; j++)
            if (request[j] && rr_dist(int'(ptr), j) < best_d) begin
                best_d = rr_dist(int'(ptr), j);
                win_rr = OUTPUT_WIDTH'(j);
            end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        onehot_d = onehot_q;
        last_d   = accept ? index_q : last_q;
        if (open_w) begin
            state_d  = (|request) ? HOLD : IDLE;
            index_d  = (|request) ? win : index_q;
            onehot_d = (|request) ? (INPUT_WIDTH'(1) << win) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            index_q  <= '0;
            onehot_q <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
        end
    end

    assign grant_valid  = (state_q == HOLD);
    assign grant_index  = index_q;
    assign grant_onehot = onehot_q;
    assign last_index   = last_q;
endmodule

// File: tb/tb_pipelined_priority_arbiter.sv
// tb_pipelined_priority_arbiter: directed checks of the arbiter at widths 8 and 5.
module tb_pipelined_priority_arbiter;
    logic       clk = 1'b0;
    logic       rst, mode, ready;
    logic [7:0] req;
    logic       gv;
    logic [2:0] gi, li;
    logic [7:0] go;
    logic [4:0] r5, go5;
    logic       m5, rd5, gv5;
    logic [2:0] gi5, li5;
    int         total = 0;
    int         bad = 0;
    int         prev;
    int         seq4[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int         seq5[5] = '{7, 3, 7, 3, 7};
    int         seq6[4] = '{4, 0, 4, 0};

    always #5 clk = ~clk;

    pipelined_priority_arbiter #(.INPUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .request(req), .mode(mode), .grant_ready(ready),
        .grant_valid(gv), .grant_index(gi), .grant_onehot(go), .last_index(li)
    );

    pipelined_priority_arbiter #(.INPUT_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .request(r5), .mode(m5), .grant_ready(rd5),
        .grant_valid(gv5), .grant_index(gi5), .grant_onehot(go5), .last_index(li5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp8(input string tag, input logic v, input int idx, input int last);
        logic [7:0] oh;
        oh = v ? (8'(1) << idx) : 8'h00;
        chk({tag, ".valid"}, 32'(gv), 32'(v));
        if (v) chk({tag, ".index"}, 32'(gi), 32'(idx));
        chk({tag, ".onehot"}, 32'(go), 32'(oh));
        chk({tag, ".last"}, 32'(li), 32'(last));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; mode = 1'b0; ready = 1'b0;
        r5 = '0; m5 = 1'b1; rd5 = 1'b1;
        #3;
        chk("reset.index", 32'(gi), 32'd0);
        exp8("reset", 1'b0, 0, 0);
        exp8("reset5", 1'b0, 0, 0);
        step; step;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step;
            exp8("idle", 1'b0, 0, 0);
        end
        req = 8'b0010_0110; ready = 1'b1;
        step; exp8("fix.first", 1'b1, 5, 0);
        step; exp8("fix.b2b", 1'b1, 5, 5);
        step; exp8("fix.b2b2", 1'b1, 5, 5);
        req = 8'b0000_0110;
        step; exp8("fix.drop5", 1'b1, 2, 5);
        req = '0;
        step; exp8("fix.toidle", 1'b0, 0, 2);
        req = 8'b1000_0001; ready = 1'b0;
        step; exp8("hold.load", 1'b1, 7, 2);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req = 8'b0000_0001;
            step; exp8("hold.sticky", 1'b1, 7, 2);
        end
        ready = 1'b1;
        step; exp8("hold.accept", 1'b1, 0, 7);
        req = '0;
        step; exp8("hold.toidle", 1'b0, 0, 0);
        mode = 1'b1; req = 8'hFF;
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            step; exp8("rr.ff", 1'b1, seq4[i], prev);
            prev = seq4[i];
        end
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst.async.valid", 32'(gv), 32'd0);
        chk("rst.async.onehot", 32'(go), 32'd0);
        chk("rst.async.last", 32'(li), 32'd0);
        step;
        rst = 1'b0;
        req = 8'b1000_1000; ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            step; exp8("rr.alt", 1'b1, seq5[i], prev);
            prev = seq5[i];
        end
        ready = 1'b0; mode = 1'b0;
        step; exp8("mode.hold", 1'b1, 7, 3);
        step; exp8("mode.hold2", 1'b1, 7, 3);
        ready = 1'b1;
        step; exp8("mode.fixed", 1'b1, 7, 7);
        req = '0; ready = 1'b0;
        r5 = 5'b10001;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("w5.valid", 32'(gv5), 32'd1);
            chk("w5.index", 32'(gi5), 32'(seq6[i]));
            chk("w5.onehot", 32'(go5), 32'(5'(1) << seq6[i]));
            chk("w5.last", 32'(li5), 32'(prev));
            prev = seq6[i];
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
